exe_stage: RTL and testbench
============================

# exe_stage

Execute-stage consumer of the ID/EXE pipeline register: takes the decoded operands and control bits the decode stage latched, computes the ALU result, and resolves branches. It adds an iterative 32-cycle shift-add multiplier. While that multiplier runs, the block stalls the front of the pipeline and sends bubbles into the EXE/MEM register. It sits between the ID/EXE register outputs and the EXE/MEM register inputs, and feeds stall/branch information back to IF and ID.

## Interface
- len, 32, width of pc_in and br_addr.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- pc_in  in  len  PC of the instruction in EXE (already PC+4).
- wb_en_in, mem_read_in, mem_write_in  in  1 each  control bits from ID/EXE.
- branch_type_in  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP.
- exe_cmd_in  in  4  operation code (below).
- alu_inp1, alu_inp2  in  32 each  ALU operands.
- reg2_in  in  32  store data / BNE compare value.
- dest_in  in  5  destination register.
- alu_result  out  32  result to EXE/MEM.
- wb_en_out, mem_read_out, mem_write_out  out  1 each  gated controls to EXE/MEM.
- reg2_out  out  32  reg2_in passed through.
- dest_out  out  5  dest_in passed through.
- br_taken  out  1  branch taken; flushes IF/ID and ID/EXE.
- br_addr  out  len  branch target.
- stall  out  1  hold PC, IF/ID and ID/EXE this cycle.
- mul_busy  out  1  multiplier FSM is in BUSY.

## Operation
- Opcode map:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL; shift amount is alu_inp2[4:0].
  - 1011 MUL.
  - Any other code gives alu_result = 0.
- Arithmetic: ADD, SUB and MUL are 32-bit modulo. MUL returns the low 32 bits of the product, which are identical for signed and unsigned operands.
- Branch resolution:
  - BEZ is taken iff alu_inp1 == 0.
  - BNE is taken iff alu_inp1 != reg2_in.
  - JMP is always taken.
  - br_addr = pc_in + (alu_inp2 << 2), truncated to len bits. It is valid regardless of br_taken.
- FSM states: IDLE, BUSY, DONE. Counter is 5 bits; accumulator, multiplicand and multiplier registers are 32 bits each.
  - IDLE:
    - Non-MUL command: fully combinational pass-through, stall = 0.
    - exe_cmd_in == MUL: stall = 1; latch alu_inp1 as multiplicand and alu_inp2 as multiplier; clear the accumulator and counter; go to BUSY.
  - BUSY, each cycle:
    - if multiplier[0], add multiplicand to the accumulator;
    - shift multiplicand left 1 and multiplier right 1;
    - counter++.
    - When counter == 31 at the clock edge, go to DONE.
    - stall = 1 throughout.
  - DONE: stall = 0; alu_result = accumulator; controls pass through. Go to IDLE unconditionally, so the MUL still held in ID/EXE is not re-accepted.
- Bubble rule: whenever stall = 1, the following are all forced to 0:
  - wb_en_out, mem_read_out, mem_write_out;
  - br_taken.
- MUL carries branch_type 00; a nonzero branch_type on a MUL is ignored.
- Back-to-back MULs: the second is seen in IDLE the cycle after DONE and starts a fresh operation.

## Timing
- Non-MUL path is combinational, 0 cycles; the EXE/MEM register captures the result on the next edge.
- MUL, counting the first cycle it is presented in IDLE as cycle 0:
  - stall = 1 in cycles 0–32 (33 cycles);
  - mul_busy = 1 in cycles 1–32;
  - result and controls are valid in cycle 33, with stall = 0;
  - ID/EXE advances at the end of cycle 33.
- Reset, asynchronous:
  - state goes to IDLE; counter and datapath registers are cleared;
  - while reset is high, stall, mul_busy, br_taken, wb_en_out, mem_read_out and mem_write_out are 0.
  - Reset mid-BUSY aborts the multiply; no result is produced.
- Upstream rule: while stall = 1, ID/EXE operands must stay stable. The block latches them in cycle 0 and does not re-sample them.

## Test plan
- ADD: 7 + 0xFFFFFFFF -> alu_result = 6; wb_en_out follows wb_en_in; stall = 0.
- SRA: 0x80000000 by 4 -> 0xF8000000. SRL by 4 -> 0x08000000.
- BNE with pc_in = 0x100, alu_inp2 = 3, alu_inp1 = 5, reg2_in = 6 -> br_taken = 1, br_addr = 0x10C. BEZ with alu_inp1 = 5 -> br_taken = 0.
- MUL 0x0001_0003 × 0x0000_0005, with mem_write_in = 1 and wb_en_in = 1:
  - stall high for exactly 33 cycles and mem_write_out = 0 throughout;
  - in cycle 33, alu_result = 0x0005_000F, wb_en_out = 1, mem_write_out = 1, stall = 0.
- Two consecutive MULs (0xFFFFFFFF × 0xFFFFFFFF, then 3 × 4) -> results 0x00000001 then 0x0000000C, with one DONE cycle between the two stall windows.
- Reset asserted at BUSY cycle 10 -> stall and mul_busy drop immediately. After release with an ADD presented, the ADD result appears with stall = 0.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: combinational ALU and branch resolution, plus an iterative
// 32-cycle shift-add multiplier that stalls the front end and bubbles EXE/MEM.
module exe_stage #(
  parameter int unsigned len = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [len-1:0]   pc_in,
  input  logic             wb_en_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic [1:0]       branch_type_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic [31:0]      alu_inp1,
  input  logic [31:0]      alu_inp2,
  input  logic [31:0]      reg2_in,
  input  logic [4:0]       dest_in,
  output logic [31:0]      alu_result,
  output logic             wb_en_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic [31:0]      reg2_out,
  output logic [4:0]       dest_out,
  output logic             br_taken,
  output logic [len-1:0]   br_addr,
  output logic             stall,
  output logic             mul_busy
);

  localparam logic [3:0] CmdAdd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAnd = 4'b0100;
  localparam logic [3:0] CmdOr  = 4'b0101;
  localparam logic [3:0] CmdNor = 4'b0110;
  localparam logic [3:0] CmdXor = 4'b0111;
  localparam logic [3:0] CmdSll = 4'b1000;
  localparam logic [3:0] CmdSra = 4'b1001;
  localparam logic [3:0] CmdSrl = 4'b1010;
  localparam logic [3:0] CmdMul = 4'b1011;

  localparam logic [1:0] BrNone = 2'b00;
  localparam logic [1:0] BrBez  = 2'b01;
  localparam logic [1:0] BrBne  = 2'b10;
  localparam logic [1:0] BrJmp  = 2'b11;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;

  logic        is_mul;
  logic [31:0] alu_comb;
  logic        br_cond;
  logic [4:0]  shamt;

  assign is_mul = (exe_cmd_in == CmdMul);
  assign shamt  = alu_inp2[4:0];

  // Multiplier FSM: latch operands in IDLE, 32 shift-add steps in BUSY, one DONE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_mul) begin
            mcand_q  <= alu_inp1;
            mplier_q <= alu_inp2;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= StDone;
          end
        end
        // The MUL is still sitting in ID/EXE here; returning to IDLE without
        // re-checking the opcode keeps it from being accepted twice.
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Single-cycle ALU operations; MUL reads the accumulator.
  always_comb begin
    alu_comb = '0;
    case (exe_cmd_in)
      CmdAdd: alu_comb = alu_inp1 + alu_inp2;
      CmdSub: alu_comb = alu_inp1 - alu_inp2;
      CmdAnd: alu_comb = alu_inp1 & alu_inp2;
      CmdOr:  alu_comb = alu_inp1 | alu_inp2;
      CmdNor: alu_comb = ~(alu_inp1 | alu_inp2);
      CmdXor: alu_comb = alu_inp1 ^ alu_inp2;
      CmdSll: alu_comb = alu_inp1 << shamt;
      CmdSra: alu_comb = $unsigned($signed(alu_inp1) >>> shamt);
      CmdSrl: alu_comb = alu_inp1 >> shamt;
      CmdMul: alu_comb = acc_q;
      default: alu_comb = '0;
    endcase
  end

  // Branch condition decode.
  always_comb begin
    br_cond = 1'b0;
    case (branch_type_in)
      BrNone: br_cond = 1'b0;
      BrBez:  br_cond = (alu_inp1 == '0);
      BrBne:  br_cond = (alu_inp1 != reg2_in);
      BrJmp:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  // Stall, bubble gating and pass-through outputs. Reset gating keeps a MUL
  // held in ID/EXE from raising stall while reset is asserted.
  always_comb begin
    stall         = ~reset & (((state_q == StIdle) & is_mul) | (state_q == StBusy));
    mul_busy      = ~reset & (state_q == StBusy);
    alu_result    = (state_q == StDone) ? acc_q : alu_comb;
    wb_en_out     = wb_en_in & ~stall & ~reset;
    mem_read_out  = mem_read_in & ~stall & ~reset;
    mem_write_out = mem_write_in & ~stall & ~reset;
    // Branch fields on a MUL are ignored.
    br_taken      = br_cond & ~is_mul & ~stall & ~reset;
    br_addr       = pc_in + len'({alu_inp2, 2'b00});
    reg2_out      = reg2_in;
    dest_out      = dest_in;
  end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: driver pushes expected results, a negedge
// monitor pops and compares whenever the stage is not stalling.
module tb_exe_stage;

  logic        clock;
  logic        reset;
  logic [31:0] pc_in;
  logic        wb_en_in, mem_read_in, mem_write_in;
  logic [1:0]  branch_type_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] alu_inp1, alu_inp2, reg2_in;
  logic [4:0]  dest_in;
  logic [31:0] alu_result;
  logic        wb_en_out, mem_read_out, mem_write_out;
  logic [31:0] reg2_out;
  logic [4:0]  dest_out;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        stall, mul_busy;

  exe_stage #(.len(32)) dut (
    .clock(clock), .reset(reset), .pc_in(pc_in),
    .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .branch_type_in(branch_type_in), .exe_cmd_in(exe_cmd_in),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .reg2_in(reg2_in), .dest_in(dest_in),
    .alu_result(alu_result), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .reg2_out(reg2_out), .dest_out(dest_out),
    .br_taken(br_taken), .br_addr(br_addr), .stall(stall), .mul_busy(mul_busy)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  ctl;      // {wb, mem_read, mem_write, br_taken}
    logic [31:0] ba;
    logic [31:0] reg2;
    logic [4:0]  dest;
    int          stall_n;  // stall cycles expected before the result shows
    int          busy_n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   stall_n  = 0;
  int   busy_n   = 0;
  logic done_flag = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Reference model straight from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [63:0] ext;
    sh = 32'(b[4:0]);
    case (c)
      4'd0:  return a + b;
      4'd2:  return a - b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << sh;
      4'd9: begin
        ext = {{32{a[31]}}, a};
        ext = ext >> sh;
        return ext[31:0];
      end
      4'd10: return a >> sh;
      4'd11: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r2, input logic [31:0] pc, input logic [1:0] bt,
                       input logic wb, input logic mr, input logic mw, input logic [4:0] d);
    exp_t e;
    bit   taken;
    bit   ok;
    exe_cmd_in = cmd; alu_inp1 = a; alu_inp2 = b; reg2_in = r2; pc_in = pc;
    branch_type_in = bt; wb_en_in = wb; mem_read_in = mr; mem_write_in = mw; dest_in = d;
    taken = (bt == 2'd1 && a == 0) || (bt == 2'd2 && a != r2) || (bt == 2'd3);
    if (cmd == 4'd11) taken = 1'b0;
    e.res  = ref_alu(cmd, a, b);
    e.ctl  = {wb, mr, mw, taken};
    e.ba   = pc + b * 32'd4;
    e.reg2 = r2;
    e.dest = d;
    e.stall_n = (cmd == 4'd11) ? 33 : 0;
    e.busy_n  = (cmd == 4'd11) ? 32 : 0;
    sb.push_back(e);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (!stall) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL issue_timeout: stall still 1 after 100 cycles, expected 0");
      $fatal(1);
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: checks bubbles while stalled, pops the scoreboard when not.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      chk("reset_outs", 32'({stall, mul_busy, br_taken, wb_en_out, mem_read_out,
                             mem_write_out}), 32'd0);
      stall_n = 0;
      busy_n  = 0;
    end else if (stall) begin
      stall_n++;
      if (mul_busy) busy_n++;
      chk("bubble", 32'({wb_en_out, mem_read_out, mem_write_out, br_taken}), 32'd0);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("alu_result", alu_result, e.res);
      chk("ctl_out", 32'({wb_en_out, mem_read_out, mem_write_out, br_taken}), 32'(e.ctl));
      chk("br_addr", br_addr, e.ba);
      chk("reg2_out", reg2_out, e.reg2);
      chk("dest_out", 32'(dest_out), 32'(e.dest));
      chk("stall_cycles", 32'(stall_n), 32'(e.stall_n));
      chk("busy_cycles", 32'(busy_n), 32'(e.busy_n));
      chk("mul_busy_low", 32'(mul_busy), 32'd0);
      stall_n = 0;
      busy_n  = 0;
    end
    if (done_flag) begin
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b, r2;
    reset = 1'b1;
    pc_in = 32'h0; wb_en_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    branch_type_in = 2'b00; exe_cmd_in = 4'd0; alu_inp1 = '0; alu_inp2 = '0;
    reg2_in = '0; dest_in = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Directed cases.
    issue(4'd0,  32'd7, 32'hFFFF_FFFF, 32'h1234, 32'h40, 2'b00, 1'b1, 1'b0, 1'b0, 5'd3);
    issue(4'd9,  32'h8000_0000, 32'd4, 32'h0, 32'h44, 2'b00, 1'b1, 1'b0, 1'b0, 5'd4);
    issue(4'd10, 32'h8000_0000, 32'd4, 32'h0, 32'h48, 2'b00, 1'b1, 1'b0, 1'b0, 5'd5);
    issue(4'd0,  32'd5, 32'd3, 32'd6, 32'h100, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
    issue(4'd0,  32'd5, 32'd3, 32'd6, 32'h100, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0);
    issue(4'd11, 32'h0001_0003, 32'd5, 32'hABCD, 32'h200, 2'b00, 1'b1, 1'b0, 1'b1, 5'd9);
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h204, 2'b11, 1'b1, 1'b0, 1'b0, 5'd1);
    issue(4'd11, 32'd3, 32'd4, 32'h0, 32'h208, 2'b00, 1'b1, 1'b1, 1'b0, 5'd2);

    // Reset in the middle of a multiply: no result expected for it.
    exe_cmd_in = 4'd11; alu_inp1 = 32'd9; alu_inp2 = 32'd9; wb_en_in = 1'b1;
    mem_write_in = 1'b1; branch_type_in = 2'b00;
    repeat (11) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    issue(4'd0, 32'd10, 32'd20, 32'h5, 32'h300, 2'b00, 1'b1, 1'b0, 1'b0, 5'd7);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      c  = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      b  = 32'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      issue(c, a, b, r2, 32'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom));
    end
    issue(4'd0, 32'd1, 32'd1, 32'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    done_flag = 1'b1;
  end

endmodule
